// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: main FSM with a memory-ready handshake and a wait-state
// watchdog, plus ALU, branch and immediate decode.
module mc_control_unit #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned ALUC_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        op,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              mem_req,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [2:0]        ImmSrc,
  output logic              instr_done,
  output logic              fault,
  output logic [3:0]        state_dbg
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_LUI      = 4'd12,
    S_FAULT    = 4'd15
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rdy, wd_hit, taken, mem_state;
  logic [3:0]       funct_op, alu_op;
  logic             pc_write_c, mem_req_c, mem_write_c, ir_write_c, reg_write_c;

  assign rdy       = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign wd_hit    = (TIMEOUT != 0) && !rdy && (wait_cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Wait counter runs only while a memory state is stalled in place.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_state && !rdy && (state_d == state_q)) wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  always_comb begin
    funct_op = ALU_ADD;
    case (funct3)
      3'b000:  funct_op = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  funct_op = ALU_SLL;
      3'b010:  funct_op = ALU_SLT;
      3'b011:  funct_op = ALU_SLTU;
      3'b100:  funct_op = ALU_XOR;
      3'b101:  funct_op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  funct_op = ALU_OR;
      default: funct_op = ALU_AND;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_c  = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_c = rdy;
        pc_write_c = rdy;
        if (rdy)         state_d = S_DECODE;
        else if (wd_hit) state_d = S_FAULT;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
          7'b1100111:             state_d = S_JALRADR;
          7'b1100011:             state_d = S_BRANCH;
          7'b0110111:             state_d = S_LUI;
          7'b0010111:             state_d = S_ALUWB;
          default:                state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        mem_req_c = 1'b1;
        if (rdy)         state_d = S_MEMWB;
        else if (wd_hit) state_d = S_FAULT;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        if (rdy)         state_d = S_FETCH;
        else if (wd_hit) state_d = S_FAULT;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_op  = funct_op;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JAL;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        ResultSrc   = 2'b11;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALU_SUB;
        if (funct3[2:1] == 2'b01) state_d = S_FAULT;
        else begin
          pc_write_c = taken;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_FAULT;
    endcase
  end

  // Strobes are forced low while reset is held.
  assign PCWrite    = reset && pc_write_c;
  assign mem_req    = reset && mem_req_c;
  assign MemWrite   = reset && mem_write_c;
  assign IRWrite    = reset && ir_write_c;
  assign RegWrite   = reset && reg_write_c;
  assign instr_done = reset && (state_d == S_FETCH) && (state_q != S_FETCH);
  assign fault      = reset && (state_q == S_FAULT);
  assign ALUControl = ALUC_W'(alu_op);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: instance a uses TIMEOUT 16, instance b TIMEOUT 4 / ALUC_W 5.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, ltu, mem_ready;

  logic       a_pcw, a_adr, a_req, a_mw, a_irw, a_rw, a_done, a_fault;
  logic [1:0] a_res, a_sa, a_sb;
  logic [3:0] a_alu, a_st;
  logic [2:0] a_imm;
  logic       b_pcw, b_adr, b_req, b_mw, b_irw, b_rw, b_done, b_fault;
  logic [1:0] b_res, b_sa, b_sb;
  logic [4:0] b_alu;
  logic [3:0] b_st;
  logic [2:0] b_imm;

  int checks = 0;
  int failures = 0;

  // {state, PCWrite, IRWrite, RegWrite, MemWrite, mem_req, instr_done, fault}
  wire [10:0] a_sv  = {a_st, a_pcw, a_irw, a_rw, a_mw, a_req, a_done, a_fault};
  wire [10:0] b_sv  = {b_st, b_pcw, b_irw, b_rw, b_mw, b_req, b_done, b_fault};
  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB}
  wire [6:0]  a_mux = {a_adr, a_res, a_sa, a_sb};

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_HANDSHAKE(1'b1), .TIMEOUT(16), .ALUC_W(4)) u_a (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .AdrSrc(a_adr), .mem_req(a_req), .MemWrite(a_mw), .IRWrite(a_irw),
    .RegWrite(a_rw), .ResultSrc(a_res), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ALUControl(a_alu),
    .ImmSrc(a_imm), .instr_done(a_done), .fault(a_fault), .state_dbg(a_st));

  mc_control_unit #(.MEM_HANDSHAKE(1'b1), .TIMEOUT(4), .ALUC_W(5)) u_b (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
    .PCWrite(b_pcw), .AdrSrc(b_adr), .mem_req(b_req), .MemWrite(b_mw), .IRWrite(b_irw),
    .RegWrite(b_rw), .ResultSrc(b_res), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ALUControl(b_alu),
    .ImmSrc(b_imm), .instr_done(b_done), .fault(b_fault), .state_dbg(b_st));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (a_sv !== 11'b0000_0000000) begin failures++; $display("FAIL reset_strobes_a got=%b exp=%b", a_sv, 11'b0000_0000000); end
    checks++;
    if (b_sv !== 11'b0000_0000000) begin failures++; $display("FAIL reset_strobes_b got=%b exp=%b", b_sv, 11'b0000_0000000); end
    checks++;
    if (a_mux !== 7'b0_10_00_10) begin failures++; $display("FAIL reset_fetch_mux got=%b exp=%b", a_mux, 7'b0_10_00_10); end
    tick(); reset = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if (a_sv !== 11'b0000_0000100) begin failures++; $display("FAIL fetch_stall got=%b exp=%b", a_sv, 11'b0000_0000100); end
    tick(); mem_ready = 1'b1;
    #1;
    checks++;
    if (a_sv !== 11'b0000_1100100) begin failures++; $display("FAIL fetch_ready got=%b exp=%b", a_sv, 11'b0000_1100100); end
  endtask

  task automatic test_add();
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b1;
    reset_dut(); #1;
    checks++;
    if (a_sv !== 11'b0000_1100100) begin failures++; $display("FAIL add_fetch got=%b exp=%b", a_sv, 11'b0000_1100100); end
    tick(); #1;
    checks++;
    if ({a_sv, a_mux} !== {11'b0001_0000000, 7'b0_00_01_01}) begin failures++; $display("FAIL add_decode got=%b_%b", a_sv, a_mux); end
    tick(); #1;
    checks++;
    if ({a_sv, a_mux, a_alu} !== {11'b0110_0000000, 7'b0_00_10_00, 4'b0000}) begin failures++; $display("FAIL add_execr got=%b_%b_%b", a_sv, a_mux, a_alu); end
    tick(); #1;
    checks++;
    if ({a_sv, a_res} !== {11'b1000_0010010, 2'b00}) begin failures++; $display("FAIL add_aluwb got=%b_%b", a_sv, a_res); end
    tick(); #1;
    checks++;
    if (a_sv !== 11'b0000_1100100) begin failures++; $display("FAIL add_refetch got=%b exp=%b", a_sv, 11'b0000_1100100); end
  endtask

  task automatic test_lw_wait();
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    reset_dut(); tick(); tick(); #1;
    checks++;
    if ({a_sv, a_mux, a_imm} !== {11'b0010_0000000, 7'b0_00_10_01, 3'b000}) begin failures++; $display("FAIL lw_memadr got=%b_%b_%b", a_sv, a_mux, a_imm); end
    for (int i = 0; i < 3; i++) begin
      tick(); mem_ready = 1'b0; #1;
      checks++;
      if ({a_sv, a_mux} !== {11'b0011_0000100, 7'b1_00_00_00}) begin failures++; $display("FAIL lw_wait%0d got=%b_%b", i, a_sv, a_mux); end
    end
    tick(); mem_ready = 1'b1; #1;
    checks++;
    if (a_sv !== 11'b0011_0000100) begin failures++; $display("FAIL lw_ready got=%b exp=%b", a_sv, 11'b0011_0000100); end
    checks++;
    if (b_sv !== 11'b0011_0000100) begin failures++; $display("FAIL lw_ready_edge_b got=%b exp=%b", b_sv, 11'b0011_0000100); end
    tick(); #1;
    checks++;
    if ({a_sv, a_res} !== {11'b0100_0010010, 2'b01}) begin failures++; $display("FAIL lw_memwb got=%b_%b", a_sv, a_res); end
    checks++;
    if (b_sv !== 11'b0100_0010010) begin failures++; $display("FAIL lw_memwb_b got=%b exp=%b", b_sv, 11'b0100_0010010); end
  endtask

  task automatic test_sw_timeout();
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    reset_dut(); tick(); tick(); #1;
    checks++;
    if ({b_st, b_imm} !== {4'd2, 3'b001}) begin failures++; $display("FAIL sw_memadr got=%b_%b", b_st, b_imm); end
    for (int i = 0; i < 4; i++) begin
      tick(); mem_ready = 1'b0; #1;
      checks++;
      if (b_sv !== 11'b0101_0001100) begin failures++; $display("FAIL sw_wait%0d got=%b exp=%b", i, b_sv, 11'b0101_0001100); end
    end
    tick(); #1;
    checks++;
    if (b_sv !== 11'b1111_0000001) begin failures++; $display("FAIL sw_fault got=%b exp=%b", b_sv, 11'b1111_0000001); end
    for (int i = 0; i < 2; i++) begin
      tick(); mem_ready = 1'b1; #1;
      checks++;
      if (b_sv !== 11'b1111_0000001) begin failures++; $display("FAIL sw_fault_sticky%0d got=%b", i, b_sv); end
    end
    tick(); reset = 1'b0; #1;
    checks++;
    if (b_sv !== 11'b0000_0000000) begin failures++; $display("FAIL sw_fault_reset got=%b exp=0", b_sv); end
    tick(); reset = 1'b1;
  endtask

  typedef struct { logic [2:0] f3; logic z, l, lu, pcw; } br_vec_t;

  task automatic test_branch();
    br_vec_t tbl[6];
    tbl[0] = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1};
    op = 7'b1100011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      funct3 = tbl[i].f3; zero = tbl[i].z; lt = tbl[i].l; ltu = tbl[i].lu;
      reset_dut(); tick(); #1;
      checks++;
      if (a_imm !== 3'b010) begin failures++; $display("FAIL br%0d_imm got=%b exp=010", i, a_imm); end
      tick(); #1;
      checks++;
      if ({a_sv, a_alu} !== {4'd9, tbl[i].pcw, 6'b000010, 4'b0001}) begin
        failures++; $display("FAIL br%0d_branch got=%b_%b exp_pcw=%b", i, a_sv, a_alu, tbl[i].pcw);
      end
    end
    funct3 = 3'b010; zero = 1'b1; lt = 1'b1; ltu = 1'b1;
    reset_dut(); tick(); tick(); #1;
    checks++;
    if (a_sv !== 11'b1001_0000000) begin failures++; $display("FAIL br_bad_f3 got=%b exp=%b", a_sv, 11'b1001_0000000); end
    tick(); #1;
    checks++;
    if (a_sv !== 11'b1111_0000001) begin failures++; $display("FAIL br_bad_fault got=%b exp=%b", a_sv, 11'b1111_0000001); end
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
  endtask

  task automatic test_jalr_lui();
    op = 7'b1100111; funct3 = 3'b000; mem_ready = 1'b1;
    reset_dut(); tick(); tick(); #1;
    checks++;
    if ({a_sv, a_mux} !== {11'b1011_0000000, 7'b0_00_10_01}) begin failures++; $display("FAIL jalr_adr got=%b_%b", a_sv, a_mux); end
    tick(); #1;
    checks++;
    if ({a_sv, a_mux} !== {11'b1010_1000000, 7'b0_00_01_10}) begin failures++; $display("FAIL jalr_jal got=%b_%b", a_sv, a_mux); end
    tick(); #1;
    checks++;
    if (a_sv !== 11'b1000_0010010) begin failures++; $display("FAIL jalr_wb got=%b exp=%b", a_sv, 11'b1000_0010010); end
    op = 7'b0110111;
    reset_dut(); tick(); tick(); #1;
    checks++;
    if ({a_sv, a_res, a_imm} !== {11'b1100_0010010, 2'b11, 3'b100}) begin failures++; $display("FAIL lui got=%b_%b_%b", a_sv, a_res, a_imm); end
    op = 7'b0010111;
    reset_dut(); tick(); tick(); #1;
    checks++;
    if ({a_sv, a_imm} !== {11'b1000_0010010, 3'b100}) begin failures++; $display("FAIL auipc got=%b_%b", a_sv, a_imm); end
  endtask

  typedef struct { logic [6:0] o; logic [2:0] f3; logic f7; logic [3:0] st; logic [3:0] alu; } alu_vec_t;

  task automatic test_alu_decode();
    alu_vec_t tbl[10];
    tbl[0] = '{7'b0110011, 3'b000, 1'b1, 4'd6, 4'b0001};
    tbl[1] = '{7'b0010011, 3'b000, 1'b1, 4'd7, 4'b0000};
    tbl[2] = '{7'b0010011, 3'b101, 1'b1, 4'd7, 4'b1001};
    tbl[3] = '{7'b0110011, 3'b101, 1'b0, 4'd6, 4'b1000};
    tbl[4] = '{7'b0110011, 3'b011, 1'b0, 4'd6, 4'b0110};
    tbl[5] = '{7'b0010011, 3'b010, 1'b0, 4'd7, 4'b0101};
    tbl[6] = '{7'b0110011, 3'b001, 1'b0, 4'd6, 4'b0111};
    tbl[7] = '{7'b0110011, 3'b100, 1'b0, 4'd6, 4'b0100};
    tbl[8] = '{7'b0110011, 3'b110, 1'b0, 4'd6, 4'b0011};
    tbl[9] = '{7'b0010011, 3'b111, 1'b0, 4'd7, 4'b0010};
    mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = tbl[i].o; funct3 = tbl[i].f3; funct7b5 = tbl[i].f7;
      reset_dut(); tick(); tick(); #1;
      checks++;
      if ({a_st, a_alu, b_alu} !== {tbl[i].st, tbl[i].alu, 1'b0, tbl[i].alu}) begin
        failures++; $display("FAIL alu%0d got st=%0d a=%b b=%b exp st=%0d alu=%b", i, a_st, a_alu, b_alu, tbl[i].st, tbl[i].alu);
      end
    end
    op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
    reset_dut(); tick(); tick(); #1;
    checks++;
    if (a_sv !== 11'b1111_0000001) begin failures++; $display("FAIL illegal_op got=%b exp=%b", a_sv, 11'b1111_0000001); end
  endtask

  task automatic test_mid_reset();
    op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
    reset_dut(); tick(); tick();
    tick(); mem_ready = 1'b0;
    tick(); #1;
    checks++;
    if ({a_sv, u_a.wait_cnt_q} !== {11'b0101_0001100, 4'd1}) begin failures++; $display("FAIL midrst_wait got=%b_%0d", a_sv, u_a.wait_cnt_q); end
    #2; reset = 1'b0; #1;
    checks++;
    if ({a_mw, a_req, a_st} !== {1'b0, 1'b0, 4'd0}) begin failures++; $display("FAIL midrst_drop got mw=%b req=%b st=%0d", a_mw, a_req, a_st); end
    tick(); reset = 1'b1; #1;
    checks++;
    if ({a_st, a_fault, u_a.wait_cnt_q} !== {4'd0, 1'b0, 4'd0}) begin failures++; $display("FAIL midrst_release got st=%0d fault=%b cnt=%0d", a_st, a_fault, u_a.wait_cnt_q); end
    mem_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_timeout();
    test_branch();
    test_jalr_lui();
    test_alu_decode();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Second-generation control unit for the multi-cycle RV32I core: one FSM plus ALU, branch and immediate decoders in a single block.
- Adds a memory ready handshake with a wait-state watchdog, full RV32I ALU decode, all six branch conditions, and JALR/LUI/AUIPC states.
- Adds a sticky fault state and a retire pulse.
- Sits between the instruction register and the multi-cycle datapath and memory port.

Parameters:
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready is ignored and treated as 1.
TIMEOUT, 16, maximum consecutive wait cycles in one memory state before FAULT; 0 disables the watchdog.
ALUC_W, 4, ALUControl width (minimum 4).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
op  in  7  instruction opcode
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes the access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = Result
mem_req  out  1  memory access request
MemWrite  out  1  store strobe
IRWrite  out  1  IR/OldPC enable
RegWrite  out  1  register file write
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
ALUSrcB  out  2  00 B, 01 ImmExt, 10 constant 4
ALUControl  out  ALUC_W  ALU operation
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
instr_done  out  1  one-cycle pulse when an instruction retires
fault  out  1  sticky error flag
state_dbg  out  4  current state encoding

Behaviour:
- State register and wait counter only.
  - reset low: state = FETCH (0), counter = 0.
  - While reset is low, all strobes are forced to 0: PCWrite, IRWrite, RegWrite, MemWrite, mem_req, instr_done, fault.
  - All other outputs are combinational from state and instruction fields. Mid-operation reset abandons the instruction.
- State encoding:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALRADR 11, LUI 12, FAULT 15.
  - Defaults: all strobes 0, ALUOp add.
- FETCH: AdrSrc 0, mem_req 1, SrcA 00, SrcB 10, ResultSrc 10. IRWrite = PCWrite = rdy → DECODE on rdy, else stay. (rdy = mem_ready, or 1 if MEM_HANDSHAKE = 0.)
- DECODE: SrcA 01, SrcB 01, add (OldPC+imm → ALUOut). Next state by op:
  - 0000011, 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100111 → JALRADR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - 0010111 → ALUWB (AUIPC)
  - other → FAULT
- MEMADR: SrcA 10, SrcB 01, add. → MEMWRITE if op[5], else MEMREAD.
- MEMREAD: AdrSrc 1, ResultSrc 00, mem_req 1. On rdy → MEMWB.
- MEMWB: ResultSrc 01, RegWrite → FETCH.
- MEMWRITE: AdrSrc 1, ResultSrc 00, mem_req 1, MemWrite 1 held until rdy. On rdy → FETCH.
- EXECR / EXECI: SrcA 10, SrcB 00 / 01, ALUOp funct → ALUWB.
- ALUWB: ResultSrc 00, RegWrite → FETCH.
- JALRADR: SrcA 10, SrcB 01, add → JAL.
- JAL: SrcA 01, SrcB 10, add, ResultSrc 00, PCWrite → ALUWB.
- LUI: ResultSrc 11, RegWrite → FETCH.
- BRANCH: SrcA 10, SrcB 00, sub, ResultSrc 00, PCWrite = taken → FETCH.
  - taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011 → FAULT, PCWrite 0.
- ALUControl encodings: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001. Upper bits are zero when ALUC_W > 4.
- Funct decode by funct3:
  - 000: sub iff op[5] & funct7b5, else add.
  - 001 sll, 010 slt, 011 sltu, 100 xor.
  - 101: sra iff funct7b5, else srl.
  - 110 or, 111 and.
- ImmSrc by op:
  - S for 0100011, B for 1100011, J for 1101111, U for 0110111/0010111.
  - I otherwise.
- Watchdog:
  - Counter increments each cycle in FETCH/MEMREAD/MEMWRITE with rdy = 0; clears on rdy or on any state change.
  - When counter == TIMEOUT - 1 with rdy = 0, next state = FAULT (TIMEOUT ≠ 0).
  - rdy in that same cycle wins: the access completes normally.
- FAULT: fault = 1, all strobes 0. Exit only via reset.
- instr_done = 1 in the last cycle of each instruction, i.e. any transition to FETCH from a non-FETCH state.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready tied 1 → FETCH,DECODE,EXECR,ALUWB; ALUControl 0000 in EXECR; RegWrite and instr_done 1 in ALUWB; 4 cycles.
- lw with mem_ready low 3 cycles in MEMREAD, TIMEOUT = 16 → MEMREAD held 4 cycles, mem_req 1 throughout, then MEMWB with RegWrite 1, ResultSrc 01.
- sw with mem_ready never asserted, TIMEOUT = 4 → MemWrite 1 for 4 cycles, then FAULT, fault 1, no further strobes until reset low.
- bltu with ltu = 1 → PCWrite 1 in BRANCH, ALUControl 0001. bgeu with ltu = 1 → PCWrite 0. funct3 010 → FAULT.
- jalr → JALRADR, JAL (PCWrite 1), ALUWB (RegWrite 1). lui → LUI with ResultSrc 11, ImmSrc 100.
- reset driven low in MEMWRITE mid-wait → MemWrite and mem_req drop immediately; after release state_dbg = 0, counter 0, fault 0.
